// File: rtl/matbi_cmd_burst_gen.sv
// matbi_cmd_burst_gen
// Turns one command word (start address + beat count minus one) into a burst
// of address beats on a valid/ready stream. A new command can be taken on the
// same cycle as the last beat of the current burst, so bursts run back to back.
module matbi_cmd_burst_gen #(
    parameter int CMD_WIDTH   = 32,
    parameter int ADDR_WIDTH  = CMD_WIDTH - 8,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CMD_WIDTH-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_idx,
    output logic                  m_last,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_reg;
    logic                    valid_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              idx_reg;
    logic [7:0]              len_reg;
    logic                    last_reg;
    logic                    done_reg;

    logic                    cmd_fire;
    logic                    beat_fire;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [7:0]              cmd_len;
    logic [7:0]              idx_next;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // Command fields; only consumed on an accepting handshake.
    assign cmd_addr  = ADDR_WIDTH'(s_data[CMD_WIDTH-1:8]);
    assign cmd_len   = s_data[7:0];

    // idx never passes len_reg (at most 255), so the 8-bit increment cannot wrap.
    assign idx_next  = idx_reg + 8'd1;
    // Address increments wrap naturally inside ADDR_WIDTH bits.
    assign addr_next = addr_reg + ADDR_WIDTH'(ADDR_STRIDE);

    // While bursting, a command is taken only alongside the final beat handshake.
    assign s_ready   = (state_reg == IDLE) ? 1'b1 : (m_ready & last_reg);

    assign cmd_fire  = s_valid & s_ready;
    assign beat_fire = valid_reg & m_ready;

    assign m_valid   = valid_reg;
    assign m_addr    = addr_reg;
    assign m_idx     = idx_reg;
    assign m_last    = last_reg;
    assign o_busy    = (state_reg == RUN);
    assign o_done    = done_reg;

    // Burst sequencer: loads commands, steps beats on handshake, reloads on the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            idx_reg   <= '0;
            len_reg   <= '0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= beat_fire & last_reg;
            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        state_reg <= RUN;
                        valid_reg <= 1'b1;
                        addr_reg  <= cmd_addr;
                        idx_reg   <= 8'd0;
                        len_reg   <= cmd_len;
                        last_reg  <= (cmd_len == 8'd0);
                    end
                end
                RUN: begin
                    if (beat_fire) begin
                        if (last_reg) begin
                            if (cmd_fire) begin
                                // Back-to-back: first beat of the next burst follows immediately.
                                addr_reg <= cmd_addr;
                                idx_reg  <= 8'd0;
                                len_reg  <= cmd_len;
                                last_reg <= (cmd_len == 8'd0);
                            end else begin
                                state_reg <= IDLE;
                                valid_reg <= 1'b0;
                                last_reg  <= 1'b0;
                            end
                        end else begin
                            addr_reg <= addr_next;
                            idx_reg  <= idx_next;
                            last_reg <= (idx_next == len_reg);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/matbi_cmd_burst_gen.md
MATBI_CMD_BURST_GEN -- requirements
Module: matbi_cmd_burst_gen

Interface
REQ-001 Parameter CMD_WIDTH, default 32: width of command word on s_data.
REQ-002 Parameter ADDR_WIDTH, default 24: width of m_addr; equals CMD_WIDTH-8.
REQ-003 Parameter ADDR_STRIDE, default 4: address increment per beat; SHALL be a power of two, >= 1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 s_valid  input  1  command valid from the upstream sync FIFO output.
REQ-007 s_ready  output  1  block accepts a command.
REQ-008 s_data  input  CMD_WIDTH  command: [CMD_WIDTH-1:8] start address, [7:0] LEN = beats-1.
REQ-009 m_valid  output  1  address beat valid.
REQ-010 m_ready  input  1  downstream accepts beat.
REQ-011 m_addr  output  ADDR_WIDTH  beat address.
REQ-012 m_idx  output  8  beat index within burst, 0..LEN.
REQ-013 m_last  output  1  high on the beat where m_idx == LEN.
REQ-014 o_busy  output  1  high while a burst is in progress.
REQ-015 o_done  output  1  one-cycle pulse, cycle after the last beat handshake.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE, RUN.
REQ-017 In IDLE: s_ready=1, m_valid=0; on s_valid&s_ready, latch address and LEN, set m_idx=0, go to RUN next cycle.
REQ-018 In RUN: m_valid=1; m_addr, m_idx, m_last SHALL be registered outputs, stable while m_valid&~m_ready.
REQ-019 On m_valid&m_ready with m_last=0: m_idx+1, m_addr+ADDR_STRIDE next cycle.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no carry into other fields.
REQ-021 In RUN, s_ready SHALL equal m_ready&m_last (combinational), permitting back-to-back commands with no bubble.
REQ-022 Last beat handshake with s_valid=1: load new command, stay RUN, first beat of new burst valid next cycle.
REQ-023 Last beat handshake with s_valid=0: go to IDLE, m_valid=0 next cycle.
REQ-024 LEN=0 SHALL produce exactly one beat with m_last=1.
REQ-025 LEN=255 SHALL produce 256 beats; m_idx SHALL not overflow.
REQ-026 Latency: command accept at cycle N -> first beat valid at N+1; LEN+1 beats total at full m_ready.
REQ-027 o_busy SHALL equal (state==RUN).
REQ-028 o_done SHALL pulse for one cycle in cycle after every last-beat handshake, including back-to-back.
REQ-029 m_valid SHALL never drop without a handshake once asserted (AXI-stream rule).
REQ-030 s_data SHALL be sampled only on s_valid&s_ready; other values ignored.

Reset
REQ-031 Reset SHALL act asynchronously: state=IDLE, m_valid=0, m_addr=0, m_idx=0, m_last=0, o_done=0, o_busy=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no further beats of it emitted after release.
REQ-033 After reset release, s_ready=1 on the first clock.

Verification
REQ-034 Single command s_data=0x00100003, m_ready=1 -> m_addr 0x001000,0x001004,0x001008,0x00100C; m_idx 0..3; m_last on 4th; o_done one cycle later.
REQ-035 LEN=0, s_data=0x00ABCD00 -> one beat m_addr=0x00ABCD, m_last=1; back to IDLE.
REQ-036 Wrap: s_data=0xFFFFF801 -> m_addr 0xFFFFF8, 0xFFFFFC; next would be 0x000000 (LEN=2 case checks 0x000000).
REQ-037 Back-to-back: two commands LEN=1 held in upstream FIFO, m_ready=1 -> 4 contiguous beats, no idle cycle, two o_done pulses.
REQ-038 Backpressure: random m_ready toggling on LEN=7 burst -> m_addr/m_idx/m_last stable while stalled, exactly 8 handshakes.
REQ-039 Reset asserted during beat 2 of LEN=5 burst -> all outputs 0 immediately, s_ready=1 after release, no residual beats.
